// File: rtl/mem_req_ctrl_pkg.sv
// rtl/mem_req_ctrl_pkg.sv - shared state encodings, timeout default and request decode
package mem_req_ctrl_pkg;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W           = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Exactly one of rd/wr, halfword aligned.
  function automatic logic req_valid(input logic rd, input logic wr, input logic a0);
    return (rd ^ wr) & ~a0;
  endfunction

  function automatic logic req_bad(input logic rd, input logic wr, input logic a0);
    return (rd & wr) | ((rd | wr) & a0);
  endfunction

endpackage

// File: rtl/dff_en.sv
// rtl/dff_en.sv - enabled flop with synchronous active-low reset
module dff_en #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)
      q <= RST_VAL;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - WAIT-cycle counter; tc flags that the next increment reaches LIMIT
module mem_timeout_cnt
  import mem_req_ctrl_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = clr ? '0 : cnt + 1'b1;

  dff_en #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (clr | inc),
    .d   (cnt_d),
    .q   (cnt)
  );

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - single-outstanding load/store controller between pipeline and memory
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Err,
  output logic        Stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdy
);

  logic [2:0] state_q;
  state_t     state;
  state_t     nxt;
  logic       valid;
  logic       bad;
  logic       accept;
  logic       tc;
  logic       done_d;
  logic       err_d;

  assign state  = state_t'(state_q);
  assign valid  = req_valid(Rd, Wr, Addr[0]);
  assign bad    = req_bad(Rd, Wr, Addr[0]);
  assign accept = (state == ST_IDLE) && valid;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (valid)    nxt = ST_REQ;
        else if (bad) nxt = ST_ERR;
      end
      ST_REQ:  nxt = ST_WAIT;
      // mem_rdy takes priority over an expiring timeout
      ST_WAIT: begin
        if (mem_rdy)  nxt = ST_DONE;
        else if (tc)  nxt = ST_ERR;
      end
      ST_DONE: nxt = ST_IDLE;
      ST_ERR:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  dff_en #(.W(3), .RST_VAL(ST_IDLE)) u_state (
    .clk (clk), .rst (rst), .en (1'b1), .d (nxt), .q (state_q)
  );

  dff_en #(.W(16)) u_addr (
    .clk (clk), .rst (rst), .en (accept), .d (Addr), .q (mem_addr)
  );

  dff_en #(.W(16)) u_wdata (
    .clk (clk), .rst (rst), .en (accept), .d (DataIn), .q (mem_wdata)
  );

  dff_en #(.W(1)) u_op (
    .clk (clk), .rst (rst), .en (accept), .d (Wr), .q (mem_wr)
  );

  mem_timeout_cnt #(.LIMIT(TIMEOUT)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == ST_REQ),
    .inc ((state == ST_WAIT) && !mem_rdy),
    .tc  (tc)
  );

  dff_en #(.W(16)) u_dout (
    .clk (clk), .rst (rst),
    .en  ((state == ST_WAIT) && mem_rdy && !mem_wr),
    .d   (mem_rdata), .q (DataOut)
  );

  // Done also accompanies a timeout abort so the pipeline retires the op.
  assign done_d = (nxt == ST_DONE) || ((nxt == ST_ERR) && (state == ST_WAIT));
  assign err_d  = (nxt == ST_ERR);

  dff_en #(.W(1)) u_done (
    .clk (clk), .rst (rst), .en (1'b1), .d (done_d), .q (Done)
  );

  dff_en #(.W(1)) u_err (
    .clk (clk), .rst (rst), .en (1'b1), .d (err_d), .q (Err)
  );

  dff_en #(.W(1)) u_mem_en (
    .clk (clk), .rst (rst), .en (1'b1), .d (nxt == ST_REQ), .q (mem_en)
  );

  assign Stall = (state == ST_REQ) || (state == ST_WAIT) || accept;

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Ports SHALL be, clock and reset first: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 Addr  in  16  pipeline byte address; DataIn  in  16  store data.
REQ-004 Rd  in  1  load request; Wr  in  1  store request.
REQ-005 DataOut  out  16  load result register; Done  out  1  completion pulse; Err  out  1  error pulse.
REQ-006 Stall  out  1  pipeline hold; drives the hazard unit's mStallData input.
REQ-007 mem_en  out  1  memory access strobe; mem_wr  out  1  write select; mem_addr  out  16; mem_wdata  out  16.
REQ-008 mem_rdata  in  16  read data; mem_rdy  in  1  memory completion, variable latency of 1 or more cycles after mem_en.
REQ-009 Parameter TIMEOUT, default 15, the number of WAIT cycles without mem_rdy tolerated before abort.

Function
REQ-010 A valid request SHALL be defined as (Rd XOR Wr) AND Addr[0]==0; a bad request is (Rd AND Wr), or (Rd OR Wr) with Addr[0]==1.
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, DONE and ERR.
REQ-012 IDLE with a valid request: latch Addr, DataIn and op (Wr), then go to REQ next cycle. Stall SHALL assert combinationally in this same cycle.
REQ-013 IDLE with a bad request: go to ERR, with no memory access and Stall low.
REQ-014 IDLE with no request: stay in IDLE.
REQ-015 REQ: mem_en=1 for exactly this cycle, with mem_wr, mem_addr and mem_wdata taken from the latches; clear the timeout counter; go to WAIT. mem_rdy SHALL be ignored in REQ.
REQ-016 WAIT with mem_rdy=1: on a read, capture mem_rdata into DataOut; go to DONE.
REQ-017 WAIT with mem_rdy=0: increment the 4-bit counter. When the counter equals TIMEOUT and mem_rdy=0, go to ERR. If mem_rdy=1 in the same cycle as the counter reaching TIMEOUT, mem_rdy SHALL win.
REQ-018 DONE: Done=1 and Stall=0 for one cycle, then return to IDLE unconditionally. The still-present request SHALL NOT be re-accepted.
REQ-019 ERR: Err=1 and Stall=0 for one cycle, then IDLE. Done SHALL be 1 as well when ERR was entered by timeout, and 0 for a bad request.
REQ-020 Stall SHALL be 1 in REQ and WAIT, 1 in IDLE with a valid request, and 0 otherwise.
REQ-021 DataOut SHALL hold its value until the next completed read; writes and errors SHALL NOT modify it.
REQ-022 Addr, DataIn, Rd and Wr changes while in REQ or WAIT SHALL be ignored; only the latched values drive the memory.
REQ-023 mem_addr, mem_wdata and mem_wr SHALL be held stable from REQ through WAIT. mem_en SHALL be 0 in every state except REQ.
REQ-024 Minimum read/write latency SHALL be 3 cycles from acceptance to Done: IDLE, REQ, WAIT with mem_rdy, then DONE.

Reset
REQ-025 rst==0 at a rising edge SHALL force IDLE, counter=0, DataOut=0 and all latches=0, overriding every other input and abandoning any operation in progress.
REQ-026 During and after reset SHALL hold Done=0, Err=0, mem_en=0, and Stall=0 unless a valid request is presented in IDLE.
REQ-027 A mem_rdy arriving after a mid-operation reset SHALL be ignored in IDLE.

Structure
REQ-028 State encodings (3-bit) and the TIMEOUT default SHALL live in the shared include file mem_ctrl_defs, used by this block and by its bench.
REQ-029 The state register, address/data/op latches, counter and DataOut SHALL be built from the codebase's dff_en flop.
REQ-030 The 4-bit WAIT counter SHALL be the one sub-module, mem_timeout_cnt, with clear, increment and terminal-count output.

Verification
REQ-031 Read with Addr=0x0010 and mem_rdy 1 cycle after mem_en, mem_rdata=0xBEEF -> Stall high for 3 cycles starting at the request cycle, Done pulse, DataOut=0xBEEF.
REQ-032 Write with Addr=0x0020, DataIn=0x1234 and mem_rdy after 5 WAIT cycles -> mem_wr=1, mem_wdata=0x1234 held stable throughout, Done pulse, DataOut unchanged.
REQ-033 Rd=1 with Addr=0x0003, then Rd=Wr=1 with Addr=0x0004 -> each gives an Err pulse with Done=0, mem_en never asserted, Stall never asserted.
REQ-034 Read with mem_rdy never asserted -> ERR after 15 WAIT cycles with Err=1 and Done=1; a second run with mem_rdy on the 15th WAIT cycle -> DONE, no Err.
REQ-035 rst=0 applied in the middle of WAIT, followed by a late mem_rdy -> IDLE, Stall=0, DataOut=0, no Done.
REQ-036 Back-to-back reads held across DONE -> the second read is accepted only in the IDLE cycle after DONE, with exactly one mem_en per read.
